cskip_adder_pipe: RTL and testbench
===================================

# cskip_adder_pipe

Parametrised, pipelined carry-skip adder/subtractor: the next generation of the team's 4-bit carry-skip adder. Operands of WIDTH bits are split into BLOCK-bit ripple blocks. Each block has a propagate-driven skip mux, and the blocks are distributed over registered pipeline stages behind a valid/ready handshake. The block serves as the shared add/sub unit in datapaths that need a high clock rate and flow control, and it reports skip-path usage for performance monitoring.

## Interface
Parameters:
- WIDTH, 16, operand/sum width; must be a multiple of BLOCK.
- BLOCK, 4, bits per carry-skip block. NBLK = WIDTH/BLOCK.
- BPS, 2, blocks evaluated per pipeline stage; must divide NBLK. STAGES = NBLK/BPS.
- CNT_W, 16, width of the skip-event counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  1: compute a - b (b inverted, carry-in forced to 1).
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- s  out  WIDTH  sum/difference mod 2^WIDTH.
- cout  out  1  carry-out of the MSB block (for sub: 1 = no borrow).
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
- skip_cnt  out  CNT_W  saturating count of skipped blocks in delivered results.
- clr_cnt  in  1  synchronous clear of skip_cnt.

## Operation
- Effective operands: bb = sub ? ~b : b; c0 = sub ? 1 : cin.
- Per block k: p_k = a_k ^ bb_k, bp_k = &p_k. Ripple carry-out rc_k. Block carry-out = bp_k ? (block carry-in) : rc_k. The result must equal a + bb + c0 exactly; the skip path changes timing only, never the value.
- Stage j (1..STAGES) computes blocks (j-1)*BPS .. j*BPS-1. It registers the partial sum, the inter-stage carry, the unprocessed operand slices, bp flags for the done blocks, and valid.
- Flow control: global advance en = !out_valid || out_ready. in_ready = en. The pipeline, including bubbles, shifts only when en=1.
- A beat is accepted when in_valid && in_ready. A beat is delivered when out_valid && out_ready.
- Each output register holds its value while out_valid && !out_ready.
- skip_cnt: on each delivery, add popcount(bp[NBLK-1:0]) for that result. The count saturates at 2^CNT_W-1 and does not wrap. If clr_cnt and a delivery occur in the same cycle, clr_cnt wins and skip_cnt becomes 0.
- No state machine beyond the valid shift chain; bubbles propagate as valid=0 stages.

## Timing
- Latency: a beat accepted at edge n is presented with out_valid=1 after edge n+STAGES when no stall occurs.
- Throughput: 1 beat/cycle while out_ready=1.
- Stall: out_valid=1 && out_ready=0 freezes all stages in the same cycle and drops in_ready combinationally. No beat is lost or duplicated, and order is preserved.
- Reset (async assert, any time including mid-stream): all stage valids=0, out_valid=0, s=0, cout=0, ovf=0, skip_cnt=0. In-flight beats are discarded. After deassertion, in_ready=1 on the first cycle.
- in_valid=0 with en=1 inserts a bubble. out_valid stays 0 for bubbles, and bubbles never touch skip_cnt.

## Test plan
(WIDTH=16, BLOCK=4, BPS=2, so STAGES=2.)
- Carry ripple: a=0xFFFF, b=0x0001, cin=0, sub=0 -> s=0x0000, cout=1, ovf=0, out_valid exactly 2 cycles after accept, skip_cnt += 3 (blocks 1-3 all-propagate).
- Full skip chain: a=0xAAAA, b=0x5555, cin=1 -> s=0x0000, cout=1, ovf=0, skip_cnt += 4.
- Subtract overflow: a=0x8000, b=0x0001, sub=1, cin=1 (ignored) -> s=0x7FFF, cout=1, ovf=1, skip_cnt += 2 (blocks 1-2 all-propagate).
- Backpressure: stream 8 beats with in_valid=1 and drop out_ready for 5 cycles mid-stream -> in_ready=0 while stalled; all 8 results delivered in order; the held s/cout/ovf values stay stable during the stall.
- Reset mid-operation: assert rst_n=0 with 2 beats in flight -> all outputs 0 immediately. After release, the next beat alone emerges after 2 cycles.
- Counter: preload near saturation, e.g. 0xFFFE plus a 4-skip result -> 0xFFFF and holds. Assert clr_cnt in the same cycle as a delivery -> skip_cnt=0.

Source files
------------

// File: rtl/cskip_adder_pipe.sv
// Pipelined carry-skip adder/subtractor with valid/ready flow control.
// Operands are captured on accept; each stage resolves BPS skip blocks and passes the carry onward.
module cskip_adder_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = 4,
  parameter int unsigned BPS   = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic [CNT_W-1:0] skip_cnt,
  input  logic             clr_cnt
);

  localparam int unsigned NBLK   = WIDTH / BLOCK;
  localparam int unsigned STAGES = NBLK / BPS;
  localparam int unsigned SW     = BPS * BLOCK;
  localparam int unsigned POP_W  = $clog2(NBLK + 1);
  localparam int unsigned CNTX_W = CNT_W + 1;

  logic w_en;
  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  // Operand capture: subtraction folded into inverted b and forced carry-in.
  logic             r_v0;
  logic             r_c0;
  logic [WIDTH-1:0] r_a0;
  logic [WIDTH-1:0] r_bb0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0  <= 1'b0;
      r_c0  <= 1'b0;
      r_a0  <= '0;
      r_bb0 <= '0;
    end else if (w_en) begin
      r_v0  <= in_valid;
      r_c0  <= sub | cin;
      r_a0  <= a;
      r_bb0 <= sub ? ~b : b;
    end
  end

  for (genvar j = 0; j < STAGES; j++) begin : g_stage
    localparam int unsigned DONE_W = (j + 1) * SW;
    localparam int unsigned DBP_W  = (j + 1) * BPS;

    logic [SW-1:0]     w_in_a;
    logic [SW-1:0]     w_in_bb;
    logic              w_in_c;
    logic              w_in_v;
    logic [SW-1:0]     w_sum;
    logic [BPS-1:0]    w_bp;
    logic              w_c_out;
    logic [DONE_W-1:0] w_sum_nxt;
    logic [DBP_W-1:0]  w_bp_nxt;
    logic              r_v;
    logic              r_c;
    logic [DONE_W-1:0] r_sum;
    logic [DBP_W-1:0]  r_bp;

    if (j == 0) begin : g_src
      assign w_in_a    = r_a0[SW-1:0];
      assign w_in_bb   = r_bb0[SW-1:0];
      assign w_in_c    = r_c0;
      assign w_in_v    = r_v0;
      assign w_sum_nxt = w_sum;
      assign w_bp_nxt  = w_bp;
    end else begin : g_src
      assign w_in_a    = g_stage[j-1].g_fwd.r_a[SW-1:0];
      assign w_in_bb   = g_stage[j-1].g_fwd.r_bb[SW-1:0];
      assign w_in_c    = g_stage[j-1].r_c;
      assign w_in_v    = g_stage[j-1].r_v;
      assign w_sum_nxt = {w_sum, g_stage[j-1].r_sum};
      assign w_bp_nxt  = {w_bp, g_stage[j-1].r_bp};
    end

    // Ripple inside each block; an all-propagate block forwards its carry-in directly.
    always_comb begin
      logic w_c;
      logic w_cb;
      logic w_bpk;
      logic w_pb;
      logic w_gb;
      w_sum = '0;
      w_bp  = '0;
      w_c   = w_in_c;
      w_cb  = 1'b0;
      w_bpk = 1'b0;
      w_pb  = 1'b0;
      w_gb  = 1'b0;
      for (int k = 0; k < int'(BPS); k++) begin
        w_cb  = w_c;
        w_bpk = 1'b1;
        for (int i = 0; i < int'(BLOCK); i++) begin
          w_pb = w_in_a[k*int'(BLOCK)+i] ^ w_in_bb[k*int'(BLOCK)+i];
          w_gb = w_in_a[k*int'(BLOCK)+i] & w_in_bb[k*int'(BLOCK)+i];
          w_sum[k*int'(BLOCK)+i] = w_pb ^ w_cb;
          w_cb  = w_gb | (w_pb & w_cb);
          w_bpk = w_bpk & w_pb;
        end
        w_bp[k] = w_bpk;
        w_c     = w_bpk ? w_c : w_cb;
      end
      w_c_out = w_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v   <= 1'b0;
        r_c   <= 1'b0;
        r_sum <= '0;
        r_bp  <= '0;
      end else if (w_en) begin
        r_v   <= w_in_v;
        r_c   <= w_c_out;
        r_sum <= w_sum_nxt;
        r_bp  <= w_bp_nxt;
      end
    end

    if (j < STAGES - 1) begin : g_fwd
      localparam int unsigned REM_W = WIDTH - DONE_W;
      logic [REM_W-1:0] w_rem_a;
      logic [REM_W-1:0] w_rem_bb;
      logic [REM_W-1:0] r_a;
      logic [REM_W-1:0] r_bb;

      if (j == 0) begin : g_rem
        assign w_rem_a  = r_a0[WIDTH-1:SW];
        assign w_rem_bb = r_bb0[WIDTH-1:SW];
      end else begin : g_rem
        assign w_rem_a  = g_stage[j-1].g_fwd.r_a[REM_W+SW-1:SW];
        assign w_rem_bb = g_stage[j-1].g_fwd.r_bb[REM_W+SW-1:SW];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a  <= '0;
          r_bb <= '0;
        end else if (w_en) begin
          r_a  <= w_rem_a;
          r_bb <= w_rem_bb;
        end
      end
    end

    if (j == STAGES - 1) begin : g_last
      logic r_ovf;
      // Carry into the MSB is recovered as p_msb ^ s_msb.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_en) begin
          r_ovf <= w_in_a[SW-1] ^ w_in_bb[SW-1] ^ w_sum[SW-1] ^ w_c_out;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_v;
  assign s         = g_stage[STAGES-1].r_sum;
  assign cout      = g_stage[STAGES-1].r_c;
  assign ovf       = g_stage[STAGES-1].g_last.r_ovf;

  // Saturating count of skipped blocks over delivered results.
  logic [NBLK-1:0]   w_bp_out;
  logic [POP_W-1:0]  w_pop;
  logic [CNTX_W-1:0] w_cnt_sum;
  logic [CNT_W-1:0]  r_cnt;

  assign w_bp_out = g_stage[STAGES-1].r_bp;

  always_comb begin
    w_pop = '0;
    for (int k = 0; k < int'(NBLK); k++) begin
      w_pop = w_pop + POP_W'(w_bp_out[k]);
    end
    w_cnt_sum = CNTX_W'(r_cnt) + CNTX_W'(w_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr_cnt) begin
      r_cnt <= '0;
    end else if (out_valid && out_ready) begin
      r_cnt <= w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
    end
  end

  assign skip_cnt = r_cnt;

endmodule

// File: tb/tb_cskip_adder_pipe.sv
// Bench for cskip_adder_pipe: arithmetic reference model with a latency/flow pipeline,
// compared every cycle, plus directed literal checks.
module tb_cskip_adder_pipe;

  localparam int WIDTH  = 16;
  localparam int BLOCK  = 4;
  localparam int BPS    = 2;
  localparam int CNT_W  = 16;
  localparam int NBLK   = WIDTH / BLOCK;
  localparam int STAGES = NBLK / BPS;
  localparam int W1     = WIDTH + 1;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic [CNT_W-1:0] skip_cnt;
  logic             clr_cnt = 1'b0;

  always #5 clk = ~clk;

  cskip_adder_pipe #(.WIDTH(WIDTH), .BLOCK(BLOCK), .BPS(BPS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .skip_cnt(skip_cnt), .clr_cnt(clr_cnt)
  );

  typedef struct {
    logic             v;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    int               skips;
  } res_t;

  res_t mp [STAGES+1];
  int   m_cnt = 0;
  logic m_acc = 1'b0;
  int   n_checks = 0;
  int   n_errs = 0;
  logic done = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic res_t model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tbv,
                                 input logic tc, input logic ts);
    res_t             r;
    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] px;
    logic [W1-1:0]    full;
    logic [BLOCK-1:0] nib;
    bb      = ts ? ~tbv : tbv;
    full    = {1'b0, ta} + {1'b0, bb} + W1'(ts | tc);
    r.v     = 1'b1;
    r.s     = full[WIDTH-1:0];
    r.cout  = full[WIDTH];
    r.ovf   = (ta[WIDTH-1] == bb[WIDTH-1]) && (r.s[WIDTH-1] != ta[WIDTH-1]);
    px      = ta ^ bb;
    r.skips = 0;
    for (int k = 0; k < NBLK; k++) begin
      nib = px[k*BLOCK +: BLOCK];
      if (&nib) r.skips++;
    end
    return r;
  endfunction

  // Reference pipeline: compare outputs, then advance exactly as the next edge will.
  always @(negedge clk) begin
    logic en_now;
    if (!rst_n) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_s", 32'(s), 32'd0);
      chk("rst_cout_ovf", 32'({cout, ovf}), 32'd0);
      chk("rst_skip_cnt", 32'(skip_cnt), 32'd0);
      for (int i = 0; i <= STAGES; i++) mp[i] = '{1'b0, '0, 1'b0, 1'b0, 0};
      m_cnt = 0;
      m_acc = 1'b0;
    end else begin
      en_now = !mp[STAGES].v || out_ready;
      chk("in_ready", 32'(in_ready), 32'(en_now));
      chk("out_valid", 32'(out_valid), 32'(mp[STAGES].v));
      chk("skip_cnt", 32'(skip_cnt), 32'(m_cnt));
      if (mp[STAGES].v) begin
        chk("s", 32'(s), 32'(mp[STAGES].s));
        chk("cout", 32'(cout), 32'(mp[STAGES].cout));
        chk("ovf", 32'(ovf), 32'(mp[STAGES].ovf));
      end
      m_acc = en_now && in_valid;
      if (clr_cnt) m_cnt = 0;
      else if (mp[STAGES].v && out_ready) begin
        m_cnt = m_cnt + mp[STAGES].skips;
        if (m_cnt > CMAX) m_cnt = CMAX;
      end
      if (en_now) begin
        for (int i = STAGES; i > 0; i--) mp[i] = mp[i-1];
        mp[0]   = model(a, b, cin, sub);
        mp[0].v = in_valid;
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tbv,
                      input logic tc, input logic ts);
    int g;
    g = 0;
    a = ta; b = tbv; cin = tc; sub = ts; in_valid = 1'b1;
    do begin
      @(posedge clk); #1;
      g++;
    end while (!m_acc && g < 200);
    in_valid = 1'b0;
    chk("send_accept", 32'(m_acc), 32'd1);
  endtask

  task automatic directed(input string nm, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tbv,
                          input logic tc, input logic ts, input logic [WIDTH-1:0] es,
                          input logic ec, input logic eo);
    int k;
    k = 0;
    send(ta, tbv, tc, ts);
    while (!out_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk({nm, "_latency"}, 32'(k), 32'd2);
    chk({nm, "_s"}, 32'(s), 32'(es));
    chk({nm, "_cout"}, 32'(cout), 32'(ec));
    chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    int k;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("ready_after_reset", 32'(in_ready), 32'd1);

    // Hand-computed pins for the reference model.
    r = model(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk("pin_ripple", 32'({r.s, r.cout, r.ovf, 8'(r.skips)}), 32'({16'h0000, 1'b1, 1'b0, 8'd3}));
    r = model(16'hAAAA, 16'h5555, 1'b1, 1'b0);
    chk("pin_skip", 32'({r.s, r.cout, r.ovf, 8'(r.skips)}), 32'({16'h0000, 1'b1, 1'b0, 8'd4}));
    r = model(16'h8000, 16'h0001, 1'b1, 1'b1);
    chk("pin_sub", 32'({r.s, r.cout, r.ovf, 8'(r.skips)}), 32'({16'h7FFF, 1'b1, 1'b1, 8'd2}));
    r = model(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    chk("pin_addovf", 32'({r.s, r.cout, r.ovf, 8'(r.skips)}), 32'({16'h8000, 1'b0, 1'b1, 8'd2}));

    directed("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("skip",   16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("subovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    idle(3);
    chk("cnt_directed", 32'(skip_cnt), 32'd9);

    // Backpressure mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++) send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
      end
      begin
        idle(3);
        out_ready = 1'b0;
        idle(5);
        out_ready = 1'b1;
      end
    join
    idle(6);

    // Reset with beats in flight.
    send(16'h1234, 16'h1111, 1'b0, 1'b0);
    send(16'h0F0F, 16'hF0F0, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out", 32'({out_valid, cout, ovf}), 32'd0);
    chk("midrst_s", 32'(s), 32'd0);
    chk("midrst_cnt", 32'(skip_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_ready", 32'(in_ready), 32'd1);
    directed("post_rst", 16'h0003, 16'h0004, 1'b1, 1'b0, 16'h0008, 1'b0, 1'b0);
    idle(3);

    // Randomised traffic with random stalls and bubbles.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          idle($urandom_range(0, 2));
          ra = WIDTH'($urandom);
          k  = $urandom_range(0, 2);
          if (k == 0) rb = WIDTH'($urandom);
          else if (k == 1) rb = ~ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
          else rb = ra;
          send(ra, rb, 1'($urandom), 1'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    idle(8);

    // Counter saturation: 16383*4 + 2 = 0xFFFE.
    clr_cnt = 1'b1;
    idle(1);
    clr_cnt = 1'b0;
    for (int i = 0; i < 16383; i++) send(16'hAAAA, 16'h5555, 1'b1, 1'b0);
    send(16'h8000, 16'h0001, 1'b1, 1'b1);
    idle(5);
    chk("cnt_fffe", 32'(skip_cnt), 32'h0000FFFE);
    send(16'hAAAA, 16'h5555, 1'b1, 1'b0);
    idle(5);
    chk("cnt_sat", 32'(skip_cnt), 32'h0000FFFF);
    send(16'hAAAA, 16'h5555, 1'b1, 1'b0);
    idle(5);
    chk("cnt_hold", 32'(skip_cnt), 32'h0000FFFF);

    // Clear in the same cycle as a delivery.
    send(16'hAAAA, 16'h5555, 1'b1, 1'b0);
    k = 0;
    while (!out_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    clr_cnt = 1'b1;
    idle(1);
    clr_cnt = 1'b0;
    chk("cnt_clr_wins", 32'(skip_cnt), 32'd0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
